// File: rtl/y86_pkg.sv
// Shared definitions for the sequential Y86-64 core: instruction codes,
// processor status codes and the stage-sequencer state encoding.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT  = 4'h0;
  localparam logic [3:0] ICODE_NOP   = 4'h1;
  localparam logic [3:0] ICODE_CMOV  = 4'h2;
  localparam logic [3:0] ICODE_IRMOV = 4'h3;
  localparam logic [3:0] ICODE_RMMOV = 4'h4;
  localparam logic [3:0] ICODE_MRMOV = 4'h5;
  localparam logic [3:0] ICODE_OPQ   = 4'h6;
  localparam logic [3:0] ICODE_JXX   = 4'h7;
  localparam logic [3:0] ICODE_CALL  = 4'h8;
  localparam logic [3:0] ICODE_RET   = 4'h9;
  localparam logic [3:0] ICODE_PUSH  = 4'hA;
  localparam logic [3:0] ICODE_POP   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPDATE  = 3'd6,
    S_HALTED    = 3'd7
  } seq_state_e;

  // Instructions whose memory stage must wait for the data memory handshake.
  function automatic logic uses_dmem(input logic [3:0] ic);
    return ic inside {ICODE_RMMOV, ICODE_MRMOV, ICODE_CALL,
                      ICODE_RET, ICODE_PUSH, ICODE_POP};
  endfunction

endpackage

// File: rtl/y86_cc_reg.sv
// Architectural condition-code register: ZF/SF/OF with write enable.
// Reset leaves ZF set so an untouched core reads "equal".
module y86_cc_reg
  import y86_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic we,
  input  logic zf_d,
  input  logic sf_d,
  input  logic of_d,
  output logic zf,
  output logic sf,
  output logic of
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      zf <= 1'b1;
      sf <= 1'b0;
      of <= 1'b0;
    end else if (we) begin
      zf <= zf_d;
      sf <= sf_d;
      of <= of_d;
    end
  end

endmodule

// File: rtl/y86_seq_sequencer.sv
// One-stage-per-cycle sequencer for the sequential Y86-64 core; owns CC and stat.
// Optional build macro Y86_PERF_COUNT_EN adds cycle_count / instr_count outputs.
module y86_seq_sequencer
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic        mem_ready,
  input  logic        dmem_error,
  input  logic        zf_in,
  input  logic        sf_in,
  input  logic        of_in,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        exec_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        pc_en,
  output logic        cc_en,
  output logic        zf,
  output logic        sf,
  output logic        of,
  output logic [2:0]  stat,
  output logic        halted,
  output logic [2:0]  state
`ifdef Y86_PERF_COUNT_EN
  ,
  output logic [63:0] cycle_count,
  output logic [63:0] instr_count
`endif
);

  seq_state_e state_q, state_d;
  logic [3:0] icode_q;
  logic [2:0] stat_q, stat_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      icode_q <= ICODE_HALT;
      stat_q  <= STAT_AOK;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      if (state_q == S_FETCH) icode_q <= icode;
    end
  end

  // NOTE: defaults first so every path assigns state_d/stat_d and no latch is inferred.
  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    unique case (state_q)
      S_IDLE:      if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_error) begin
          state_d = S_HALTED;
          stat_d  = STAT_ADR;
        end else if (!instr_valid) begin
          state_d = S_HALTED;
          stat_d  = STAT_INS;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = S_MEMORY;
      S_MEMORY: begin
        // dmem_error only means something in the cycle mem_ready completes.
        if (!uses_dmem(icode_q)) begin
          state_d = S_WRITEBACK;
        end else if (mem_ready) begin
          if (dmem_error) begin
            state_d = S_HALTED;
            stat_d  = STAT_ADR;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: state_d = S_PCUPDATE;
      S_PCUPDATE: begin
        if (icode_q == ICODE_HALT) begin
          state_d = S_HALTED;
          stat_d  = STAT_HLT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALTED:    state_d = S_HALTED;
      default:     state_d = S_IDLE;
    endcase
  end

  assign fetch_en  = (state_q == S_FETCH);
  assign decode_en = (state_q == S_DECODE);
  assign exec_en   = (state_q == S_EXECUTE);
  assign mem_en    = (state_q == S_MEMORY);
  assign wb_en     = (state_q == S_WRITEBACK);
  assign pc_en     = (state_q == S_PCUPDATE);
  assign cc_en     = exec_en && (icode_q == ICODE_OPQ);
  assign halted    = (state_q == S_HALTED);
  assign stat      = stat_q;
  assign state     = state_q;

  y86_cc_reg u_cc (
    .clk   (clk),
    .reset (reset),
    .we    (cc_en),
    .zf_d  (zf_in),
    .sf_d  (sf_in),
    .of_d  (of_in),
    .zf    (zf),
    .sf    (sf),
    .of    (of)
  );

`ifdef Y86_PERF_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= 64'd0;
      instr_count <= 64'd0;
    end else begin
      if (state_q != S_IDLE && state_q != S_HALTED) cycle_count <= cycle_count + 64'd1;
      // PCUPDATE always leaves to FETCH or HALTED, so each visit retires one instruction.
      if (state_q == S_PCUPDATE) instr_count <= instr_count + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_y86_seq_sequencer.sv
// Cycle-table bench for y86_seq_sequencer: each row drives one cycle of inputs and
// the expected registered outputs for that cycle; a negedge scoreboard compares.
module tb_y86_seq_sequencer;
  import y86_pkg::*;

  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
  localparam logic [2:0] F0 = 3'b100;  // {zf,sf,of} reset value
  localparam logic [3:0] XI = 4'hF;    // don't-care icode outside FETCH

  logic clk = 1'b0;
  logic reset, start, instr_valid, imem_error, mem_ready, dmem_error;
  logic zf_in, sf_in, of_in;
  logic [3:0] icode;
  logic fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, cc_en;
  logic zf, sf, of, halted;
  logic [2:0] stat, state;
`ifdef Y86_PERF_COUNT_EN
  logic [63:0] cycle_count, instr_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  y86_seq_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .icode(icode),
    .instr_valid(instr_valid), .imem_error(imem_error),
    .mem_ready(mem_ready), .dmem_error(dmem_error),
    .zf_in(zf_in), .sf_in(sf_in), .of_in(of_in),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
    .mem_en(mem_en), .wb_en(wb_en), .pc_en(pc_en), .cc_en(cc_en),
    .zf(zf), .sf(sf), .of(of), .stat(stat), .halted(halted), .state(state)
`ifdef Y86_PERF_COUNT_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  typedef struct {
    string      name;
    logic       rst, st;
    logic [3:0] ic;
    logic       vld, ie, mr, de;
    logic [2:0] fin;
    seq_state_e s;
    logic       cc;
    logic [2:0] fl;
    logic [2:0] sv;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] onehot(input seq_state_e s);
    case (s)
      S_FETCH:     return 6'b100000;
      S_DECODE:    return 6'b010000;
      S_EXECUTE:   return 6'b001000;
      S_MEMORY:    return 6'b000100;
      S_WRITEBACK: return 6'b000010;
      S_PCUPDATE:  return 6'b000001;
      default:     return 6'b000000;
    endcase
  endfunction

  task automatic add(input string n, input logic rst, input logic st, input logic [3:0] ic,
                     input logic vld, input logic ie, input logic mr, input logic de,
                     input logic [2:0] fin, input seq_state_e s, input logic cc,
                     input logic [2:0] fl, input logic [2:0] sv);
    vec_t t;
    t.name = n; t.rst = rst; t.st = st; t.ic = ic; t.vld = vld; t.ie = ie;
    t.mr = mr; t.de = de; t.fin = fin; t.s = s; t.cc = cc; t.fl = fl; t.sv = sv;
    vecs.push_back(t);
  endtask

  task automatic drive(input vec_t t);
    reset = t.rst; start = t.st; icode = t.ic; instr_valid = t.vld;
    imem_error = t.ie; mem_ready = t.mr; dmem_error = t.de;
    {zf_in, sf_in, of_in} = t.fin;
    sb.push_back(t);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : scoreboard
    vec_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.name, ":state"}, 64'(state), 64'(e.s));
      check({e.name, ":enables"},
            64'({fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en}), 64'(onehot(e.s)));
      check({e.name, ":cc_en"}, 64'(cc_en), 64'(e.cc));
      check({e.name, ":flags"}, 64'({zf, sf, of}), 64'(e.fl));
      check({e.name, ":stat"}, 64'(stat), 64'(e.sv));
      check({e.name, ":halted"}, 64'(halted), 64'(e.s == S_HALTED));
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; icode = 4'h0; instr_valid = 1'b0;
    imem_error = 1'b0; mem_ready = 1'b0; dmem_error = 1'b0;
    {zf_in, sf_in, of_in} = 3'b000;

    // Reset wins over every active input; start only works from IDLE.
    add("rst_a",  1,1,4'h1,1,1,1,1,3'b111, S_IDLE,0,F0,AOK);
    add("rst_b",  1,0,4'h1,1,0,0,0,3'b000, S_IDLE,0,F0,AOK);
    add("idle",   0,0,4'h1,1,0,0,0,3'b000, S_IDLE,0,F0,AOK);
    add("start",  0,1,XI,  0,0,0,0,3'b000, S_IDLE,0,F0,AOK);
    // nop: dmem_error/mem_ready ignored in MEMORY, start ignored mid-instruction
    add("nop_f",  0,0,ICODE_NOP,1,0,0,0,3'b000, S_FETCH,0,F0,AOK);
    add("nop_d",  0,1,XI,0,0,0,0,3'b000, S_DECODE,0,F0,AOK);
    add("nop_e",  0,0,XI,0,0,0,0,3'b011, S_EXECUTE,0,F0,AOK);
    add("nop_m",  0,0,XI,0,0,1,1,3'b000, S_MEMORY,0,F0,AOK);
    add("nop_w",  0,0,XI,0,0,0,0,3'b000, S_WRITEBACK,0,F0,AOK);
    add("nop_p",  0,0,XI,0,0,0,0,3'b000, S_PCUPDATE,0,F0,AOK);
    // irmov with flag inputs present: no capture
    add("irm_f",  0,0,ICODE_IRMOV,1,0,0,0,3'b000, S_FETCH,0,F0,AOK);
    add("irm_d",  0,0,XI,0,0,0,0,3'b000, S_DECODE,0,F0,AOK);
    add("irm_e",  0,0,XI,0,0,0,0,3'b010, S_EXECUTE,0,F0,AOK);
    add("irm_m",  0,0,XI,0,0,0,0,3'b010, S_MEMORY,0,F0,AOK);
    add("irm_w",  0,0,XI,0,0,0,0,3'b000, S_WRITEBACK,0,F0,AOK);
    add("irm_p",  0,0,XI,0,0,0,0,3'b000, S_PCUPDATE,0,F0,AOK);
    // opq: capture ZF=0 SF=1 OF=0, visible from MEMORY
    add("opq_f",  0,0,ICODE_OPQ,1,0,0,0,3'b000, S_FETCH,0,F0,AOK);
    add("opq_d",  0,0,XI,0,0,0,0,3'b000, S_DECODE,0,F0,AOK);
    add("opq_e",  0,0,XI,0,0,0,0,3'b010, S_EXECUTE,1,F0,AOK);
    add("opq_m",  0,0,XI,0,0,0,0,3'b111, S_MEMORY,0,3'b010,AOK);
    add("opq_w",  0,0,XI,0,0,0,0,3'b000, S_WRITEBACK,0,3'b010,AOK);
    add("opq_p",  0,0,XI,0,0,0,0,3'b000, S_PCUPDATE,0,3'b010,AOK);
    // mrmov: mem_ready on third MEMORY cycle; unqualified dmem_error ignored
    add("mrm_f",  0,0,ICODE_MRMOV,1,0,0,0,3'b000, S_FETCH,0,3'b010,AOK);
    add("mrm_d",  0,0,XI,0,0,0,0,3'b000, S_DECODE,0,3'b010,AOK);
    add("mrm_e",  0,0,XI,0,0,0,0,3'b101, S_EXECUTE,0,3'b010,AOK);
    add("mrm_m0", 0,0,XI,0,0,0,1,3'b000, S_MEMORY,0,3'b010,AOK);
    add("mrm_m1", 0,0,XI,0,0,0,0,3'b000, S_MEMORY,0,3'b010,AOK);
    add("mrm_m2", 0,0,XI,0,0,1,0,3'b000, S_MEMORY,0,3'b010,AOK);
    add("mrm_w",  0,0,XI,0,0,0,0,3'b000, S_WRITEBACK,0,3'b010,AOK);
    add("mrm_p",  0,0,XI,0,0,0,0,3'b000, S_PCUPDATE,0,3'b010,AOK);
    // halt: pc_en still in PCUPDATE, then sticky HALTED ignoring start
    add("hlt_f",  0,0,ICODE_HALT,1,0,0,0,3'b000, S_FETCH,0,3'b010,AOK);
    add("hlt_d",  0,0,XI,0,0,0,0,3'b000, S_DECODE,0,3'b010,AOK);
    add("hlt_e",  0,0,XI,0,0,0,0,3'b000, S_EXECUTE,0,3'b010,AOK);
    add("hlt_m",  0,0,XI,0,0,0,0,3'b000, S_MEMORY,0,3'b010,AOK);
    add("hlt_w",  0,0,XI,0,0,0,0,3'b000, S_WRITEBACK,0,3'b010,AOK);
    add("hlt_p",  0,1,XI,0,0,0,0,3'b000, S_PCUPDATE,0,3'b010,AOK);
    add("hlt_h0", 0,1,ICODE_NOP,1,0,1,0,3'b000, S_HALTED,0,3'b010,HLT);
    add("hlt_h1", 0,1,ICODE_NOP,1,0,0,0,3'b000, S_HALTED,0,3'b010,HLT);

    // imem_error beats !instr_valid
    add("adr_rst",  1,0,XI,0,0,0,0,3'b000, S_HALTED,0,3'b010,HLT);
    add("adr_st",   0,1,XI,0,0,0,0,3'b000, S_IDLE,0,F0,AOK);
    add("adr_f",    0,0,ICODE_NOP,0,1,0,0,3'b000, S_FETCH,0,F0,AOK);
    add("adr_h",    0,0,XI,0,0,0,0,3'b000, S_HALTED,0,F0,ADR);
    // illegal instruction
    add("ins_rst",  1,0,XI,0,0,0,0,3'b000, S_HALTED,0,F0,ADR);
    add("ins_st",   0,1,XI,0,0,0,0,3'b000, S_IDLE,0,F0,AOK);
    add("ins_f",    0,0,4'hC,0,0,0,0,3'b000, S_FETCH,0,F0,AOK);
    add("ins_h",    0,0,XI,0,0,0,0,3'b000, S_HALTED,0,F0,INS);
    // call with mem_ready in first MEMORY cycle (N=0), then push hitting dmem_error
    add("call_rst", 1,0,XI,0,0,0,0,3'b000, S_HALTED,0,F0,INS);
    add("call_st",  0,1,XI,0,0,0,0,3'b000, S_IDLE,0,F0,AOK);
    add("call_f",   0,0,ICODE_CALL,1,0,0,0,3'b000, S_FETCH,0,F0,AOK);
    add("call_d",   0,0,XI,0,0,0,0,3'b000, S_DECODE,0,F0,AOK);
    add("call_e",   0,0,XI,0,0,0,0,3'b000, S_EXECUTE,0,F0,AOK);
    add("call_m",   0,0,XI,0,0,1,0,3'b000, S_MEMORY,0,F0,AOK);
    add("call_w",   0,0,XI,0,0,0,0,3'b000, S_WRITEBACK,0,F0,AOK);
    add("call_p",   0,0,XI,0,0,0,0,3'b000, S_PCUPDATE,0,F0,AOK);
    add("push_f",   0,0,ICODE_PUSH,1,0,0,0,3'b000, S_FETCH,0,F0,AOK);
    add("push_d",   0,0,XI,0,0,0,0,3'b000, S_DECODE,0,F0,AOK);
    add("push_e",   0,0,XI,0,0,0,0,3'b000, S_EXECUTE,0,F0,AOK);
    add("push_m",   0,0,XI,0,0,1,1,3'b000, S_MEMORY,0,F0,AOK);
    add("push_h",   0,1,XI,0,0,0,0,3'b000, S_HALTED,0,F0,ADR);
    // reset during a MEMORY wait restores every reset value, including flags
    add("rmw_rst",  1,0,XI,0,0,0,0,3'b000, S_HALTED,0,F0,ADR);
    add("rmw_st",   0,1,XI,0,0,0,0,3'b000, S_IDLE,0,F0,AOK);
    add("rmw_of",   0,0,ICODE_OPQ,1,0,0,0,3'b000, S_FETCH,0,F0,AOK);
    add("rmw_od",   0,0,XI,0,0,0,0,3'b000, S_DECODE,0,F0,AOK);
    add("rmw_oe",   0,0,XI,0,0,0,0,3'b001, S_EXECUTE,1,F0,AOK);
    add("rmw_om",   0,0,XI,0,0,0,0,3'b000, S_MEMORY,0,3'b001,AOK);
    add("rmw_ow",   0,0,XI,0,0,0,0,3'b000, S_WRITEBACK,0,3'b001,AOK);
    add("rmw_op",   0,0,XI,0,0,0,0,3'b000, S_PCUPDATE,0,3'b001,AOK);
    add("rmw_mf",   0,0,ICODE_POP,1,0,0,0,3'b000, S_FETCH,0,3'b001,AOK);
    add("rmw_md",   0,0,XI,0,0,0,0,3'b000, S_DECODE,0,3'b001,AOK);
    add("rmw_me",   0,0,XI,0,0,0,0,3'b000, S_EXECUTE,0,3'b001,AOK);
    add("rmw_m0",   0,0,XI,0,0,0,0,3'b000, S_MEMORY,0,3'b001,AOK);
    add("rmw_m1",   1,0,XI,0,0,1,1,3'b000, S_MEMORY,0,3'b001,AOK);
    add("rmw_idle", 0,0,XI,0,0,1,0,3'b000, S_IDLE,0,F0,AOK);
`ifdef Y86_PERF_COUNT_EN
    add("pc_rst",   1,0,XI,0,0,0,0,3'b000, S_IDLE,0,F0,AOK);
    add("pc_st",    0,1,XI,0,0,0,0,3'b000, S_IDLE,0,F0,AOK);
    for (int k = 0; k < 2; k++) begin
      add("pc_f", 0,0,ICODE_NOP,1,0,0,0,3'b000, S_FETCH,0,F0,AOK);
      add("pc_d", 0,0,XI,0,0,0,0,3'b000, S_DECODE,0,F0,AOK);
      add("pc_e", 0,0,XI,0,0,0,0,3'b000, S_EXECUTE,0,F0,AOK);
      add("pc_m", 0,0,XI,0,0,0,0,3'b000, S_MEMORY,0,F0,AOK);
      add("pc_w", 0,0,XI,0,0,0,0,3'b000, S_WRITEBACK,0,F0,AOK);
      add("pc_p", 0,0,XI,0,0,0,0,3'b000, S_PCUPDATE,0,F0,AOK);
    end
`endif

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);

`ifdef Y86_PERF_COUNT_EN
    // Now in the FETCH that follows the second nop.
    check("perf:state", 64'(state), 64'(S_FETCH));
    check("perf:instr_count", instr_count, 64'd2);
    check("perf:cycle_count", cycle_count, 64'd12);
`endif
    check("sb_drain", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
